// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the fetch/datapath side.
// master = sequencer, slave = memory/IR/datapath side.
interface multicycle_control_fsm_if #(parameter int OPW = 4);
  logic           run;
  logic [OPW-1:0] opcode;
  logic           mem_ack;
  logic           mem_req;
  logic           esc_ir;
  logic           esc_cp;
  logic           esc_cond_cp;
  logic           ula_a;
  logic [1:0]     ula_b;
  logic [OPW-1:0] ula_op;
  logic [1:0]     fonte_cp;
  logic           esc_reg;
  logic           instr_done;
  logic           fault;

  modport master (
    input  run, opcode, mem_ack,
    output mem_req, esc_ir, esc_cp, esc_cond_cp, ula_a, ula_b, ula_op,
           fonte_cp, esc_reg, instr_done, fault
  );

  modport slave (
    output run, opcode, mem_ack,
    input  mem_req, esc_ir, esc_cp, esc_cond_cp, ula_a, ula_b, ula_op,
           fonte_cp, esc_reg, instr_done, fault
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: fetch over req/ack, decode, then execute/writeback,
// branch or jump. Outputs decode the registered state; fetch completion follows mem_ack.
module multicycle_control_fsm #(
  parameter int             OPW     = 4,
  parameter logic [OPW-1:0] ALU_ADD = '0,
  parameter logic [OPW-1:0] ALU_SUB = OPW'(1),
  parameter int             TIMEOUT = 15
) (
  input logic clk,
  input logic rst_n,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, EXEC_I, WB, BRANCH, JUMP, FAULT
  } state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic           fault_q;
  logic [OPW-1:0] op_q;

  function automatic state_t dec_next(input logic [OPW-1:0] op);
    case (op)
      4'd0, 4'd1, 4'd3, 4'd4, 4'd5:         dec_next = EXEC_R;
      4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: dec_next = EXEC_I;
      4'd11:                                dec_next = JUMP;
      4'd12:                                dec_next = BRANCH;
      default:                              dec_next = FETCH;
    endcase
  endfunction

  function automatic logic is_imm(input logic [OPW-1:0] op);
    is_imm = (dec_next(op) == EXEC_I);
  endfunction

  function automatic logic is_illegal(input logic [OPW-1:0] op);
    is_illegal = (dec_next(op) == FETCH);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      fault_q <= 1'b0;
      op_q    <= '0;
    end else begin
      case (state)
        IDLE:   if (bus.run) state <= FETCH;
        FETCH: begin
          // ack wins even on the last allowed wait cycle
          if (bus.mem_ack) begin
            state <= DECODE;
            cnt   <= '0;
          end else if (cnt == 4'(TIMEOUT)) begin
            state   <= FAULT;
            fault_q <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DECODE: begin
          op_q  <= bus.opcode;
          state <= dec_next(bus.opcode);
          if (is_illegal(bus.opcode)) fault_q <= 1'b1;
        end
        EXEC_R, EXEC_I:   state <= WB;
        WB, BRANCH, JUMP: state <= FETCH;
        FAULT:            state <= FAULT;
        default:          state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_req     = 1'b0;
    bus.esc_ir      = 1'b0;
    bus.esc_cp      = 1'b0;
    bus.esc_cond_cp = 1'b0;
    bus.ula_a       = 1'b0;
    bus.ula_b       = 2'b00;
    bus.ula_op      = '0;
    bus.fonte_cp    = 2'b00;
    bus.esc_reg     = 1'b0;
    bus.instr_done  = 1'b0;
    bus.fault       = fault_q;
    case (state)
      FETCH: begin
        bus.mem_req = 1'b1;
        bus.ula_b   = 2'b01;
        bus.ula_op  = ALU_ADD;
        bus.esc_ir  = bus.mem_ack;
        bus.esc_cp  = bus.mem_ack;
      end
      DECODE: begin
        bus.ula_b      = 2'b11;
        bus.ula_op     = ALU_ADD;
        bus.instr_done = is_illegal(bus.opcode);
      end
      EXEC_R: begin
        bus.ula_a  = 1'b1;
        bus.ula_op = op_q;
      end
      EXEC_I: begin
        bus.ula_a  = 1'b1;
        bus.ula_b  = 2'b10;
        bus.ula_op = op_q;
      end
      WB: begin
        bus.ula_a      = 1'b1;
        bus.ula_b      = is_imm(op_q) ? 2'b10 : 2'b00;
        bus.ula_op     = op_q;
        bus.esc_reg    = 1'b1;
        bus.instr_done = 1'b1;
      end
      BRANCH: begin
        bus.ula_a       = 1'b1;
        bus.ula_op      = ALU_SUB;
        bus.esc_cond_cp = 1'b1;
        bus.fonte_cp    = 2'b01;
        bus.instr_done  = 1'b1;
      end
      JUMP: begin
        bus.esc_cp     = 1'b1;
        bus.fonte_cp   = 2'b10;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
